// File: rtl/switch_debouncer_pkg.sv
// Shared timing/width constants for the switch debouncer and the rate divider.
package switch_debouncer_pkg;

  // 20 ms worth of 50 MHz clock cycles.
  localparam int DEBOUNCE_20MS_50MHZ = 1000000;
  // Short debounce window used in simulation.
  localparam int SIM_DEBOUNCE        = 4;
  // Speed-select width shared with the rate divider.
  localparam int SEL_W               = 2;

  // Smallest counter width able to hold n-1.
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    while ((2 ** w) <= (n - 1)) w++;
    return w;
  endfunction

endpackage

// File: rtl/switch_debouncer_debounce_bit.sv
// One switch bit: 2-flop synchroniser, stability counter, committed level
// and a one-cycle commit flag raised on the edge the level is committed.
module debounce_bit #(
  parameter int N     = 4,
  parameter int CNT_W = 3
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic i_sw,
  output logic o_stable,
  output logic o_commit
);

  logic             r_sync1, r_sync2;
  logic             r_stable;
  logic             r_commit;
  logic [CNT_W-1:0] r_cnt;
  logic             w_diff;
  logic             w_last;

  assign w_diff = (r_sync2 != r_stable);
  assign w_last = (r_cnt == CNT_W'(N - 1));

  // Plain two-flop synchroniser; nothing may sit between the flops.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_sw;
      r_sync2 <= r_sync1;
    end
  end

  // Count consecutive cycles the synchronised level differs from the
  // committed one; any return to the committed level restarts the count.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
      r_commit <= 1'b0;
    end else begin
      r_commit <= 1'b0;
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (!w_last) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
        r_commit <= 1'b1;
      end
    end
  end

  assign o_stable = r_stable;
  assign o_commit = r_commit;

endmodule

// File: rtl/switch_debouncer.sv
// Debounces WIDTH raw slide switches independently and pulses 'changed'
// for one cycle on the edge any committed bit changes.
module switch_debouncer
  import switch_debouncer_pkg::*;
#(
  parameter int WIDTH           = SEL_W,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS_50MHZ,
  parameter int CNT_W           = 20
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_out,
  output logic             changed
);

  logic [WIDTH-1:0] w_stable;
  logic [WIDTH-1:0] w_commit;

  // One independent debouncer per switch bit.
  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    debounce_bit #(
      .N     (DEBOUNCE_CYCLES),
      .CNT_W (CNT_W)
    ) u_bit (
      .Clock    (Clock),
      .Resetn   (Resetn),
      .i_sw     (sw_in[g]),
      .o_stable (w_stable[g]),
      .o_commit (w_commit[g])
    );
  end

  // Both terms are flop outputs, so sw_out/changed have no path from sw_in;
  // bits committing on the same edge yield a single pulse.
  assign sw_out  = w_stable;
  assign changed = |w_commit;

endmodule
